fifo_sync_param: RTL
====================

Name: fifo_sync_param

Overview:
- Single-clock parametrised FIFO, the next-generation general-purpose buffer for datapath and UART/peripheral staging.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and correct simultaneous read/write at the full and empty boundaries.
- Optional first-word-fall-through (FWFT) read mode.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH_LOG2, 4, log2 of storage depth; DEPTH = 2**DEPTH_LOG2 entries (>=1).
- AF_THRESH, 12, almost_full asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- data  in  WIDTH  write data.
- wr  in  1  write request.
- rd  in  1  read request (pop).
- clr_err  in  1  synchronous clear of overflow/underflow.
- fout  out  WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write rejected.
- underflow  out  1  sticky: read rejected.

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, fout=0, overflow=0, underflow=0. Therefore empty=1, full=0, almost_empty=1, and almost_full=0 unless AF_THRESH==0 (illegal). Memory contents are not reset.
- Reset asserted mid-operation discards all contents immediately. The first write after deassert lands at address 0.
- Accept rules, evaluated on pre-edge state:
  - rd_ok = rd & !empty.
  - wr_ok = wr & (!full | rd_ok). A write to a full FIFO is accepted only when a read is accepted in the same cycle.
- Empty with wr&rd: the write is accepted, the read is rejected, and underflow is set. Non-FWFT only; see Optional Feature.
- Pointers: DEPTH_LOG2-bit counters, natural wrap from DEPTH-1 to 0. wr_ptr increments on wr_ok, rd_ptr on rd_ok.
- count: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither. Never exceeds DEPTH and never goes below 0.
- Flags: decoded from the registered count only. No combinational path from wr/rd to any flag. Flags update in the cycle after the accepting edge.
- Read data (standard mode): on rd_ok, fout <= mem[rd_ptr], giving 1-cycle latency after the rd edge. fout holds its value otherwise, including on a rejected read.
- Write: on wr_ok, mem[wr_ptr] <= data.
- Simultaneous wr_ok and rd_ok at the same address (count==DEPTH, full case) reads the old entry, then overwrites it. Read-before-write.
- Errors:
  - overflow <= 1 on wr & !wr_ok.
  - underflow <= 1 on rd & !rd_ok.
  - Both hold until clr_err=1 or reset.
  - If clr_err and a new error occur in the same cycle, the error wins (flag stays 1).
- No state machine beyond the pointers and count; all outputs are registered or decoded from registers.

Optional Feature:
- Macro FIFO_FWFT_EN.
- Defined: fout continuously presents mem[rd_ptr], the head word, whenever !empty. rd acknowledges/pops the head. Data is valid in the same cycle empty=0, with no read latency. With empty=1, fout holds the last popped value. Empty with wr&rd behaves as in standard mode: the read is rejected and underflow is set. The written word appears on fout the cycle after the write.
- Undefined: standard registered read, 1-cycle latency, as in Behaviour.

Test Plan:
- Reset then 16 writes of 0x00..0x0F, no reads -> count steps 1..16. almost_full rises when count=12, full=1 at count=16, empty=0 after the first write. 16 reads -> fout returns 0x00..0x0F in order, each 1 cycle after rd. Returns to empty=1, almost_empty=1 at count<=2.
- Full FIFO, wr=1 rd=0 with data=0xAA -> overflow=1, count stays 16, contents unchanged. Pulse clr_err -> overflow=0.
- Full FIFO, wr=1 and rd=1 with data=0x55 for 1 cycle -> fout=old head 0x00, count stays 16, full stays 1. 0x55 is read back as the 16th subsequent word.
- Empty FIFO, rd=1 -> underflow=1, fout unchanged. Empty with wr=rd=1 and data=0x3C -> count=1, underflow=1, next rd returns 0x3C.
- Wrap test: 40 cycles of random interleaved wr/rd with count kept 3..13 -> output sequence equals input sequence, count always matches a reference model, no error flags.
- Write 5 words, assert rst for 1 cycle mid-burst -> count=0, empty=1, fout=0, flags cleared immediately. Next write+read returns the new data. With FIFO_FWFT_EN: fout equals first data the cycle after the first write, before any rd.

Source files
------------

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - single-clock parametrised FIFO with occupancy count, thresholds and sticky errors
//
// Purpose: general-purpose buffer for datapath and peripheral staging. Supports simultaneous
//   read/write at the full and empty boundaries. Flags are decoded from the registered count.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   data         write data (WIDTH)
//   wr           write request
//   rd           read request (pop)
//   clr_err      synchronous clear of overflow/underflow
//   fout         read data (WIDTH)
//   full         count == DEPTH
//   empty        count == 0
//   almost_full  count >= AF_THRESH
//   almost_empty count <= AE_THRESH
//   count        occupancy 0..DEPTH (DEPTH_LOG2+1)
//   overflow     sticky, a write was rejected
//   underflow    sticky, a read was rejected
// Option: define FIFO_FWFT_EN for first-word-fall-through reads. By default reads are
//   registered with a 1-cycle latency.
module fifo_sync_param #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      data,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  clr_err,
  output logic [WIDTH-1:0]      fout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AF_CNT   = (DEPTH_LOG2+1)'(AF_THRESH);
  localparam logic [DEPTH_LOG2:0] AE_CNT   = (DEPTH_LOG2+1)'(AE_THRESH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  rd_ok;
  logic                  wr_ok;

  // Flags depend only on the count register, never on wr/rd.
  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // A full FIFO can still take a write when the same edge pops an entry.
  assign rd_ok = rd & ~empty;
  assign wr_ok = wr & (~full | rd_ok);

  // Storage is not reset. When full with a read and a write on the same address,
  // the read samples the old word before this edge overwrites it.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_ok && !rd_ok) begin
        count <= count + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count <= count - 1'b1;
      end
    end
  end

  // A new error in the same cycle as clr_err takes priority over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && !wr_ok) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd && !rd_ok) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

`ifdef FIFO_FWFT_EN
  // The head word is shown while data is present. After the FIFO drains,
  // the last popped word is held.
  logic [WIDTH-1:0] last_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_pop <= '0;
    end else if (rd_ok) begin
      last_pop <= mem[rd_ptr];
    end
  end

  assign fout = empty ? last_pop : mem[rd_ptr];
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fout <= '0;
    end else if (rd_ok) begin
      fout <= mem[rd_ptr];
    end
  end
`endif

endmodule
